// File: rtl/wb_bus_arbiter.sv
// Round-robin Wishbone B4 classic arbiter sharing one slave port among NUM_M masters.
// Define WB_BUS_ARBITER_TIMEOUT_EN to compile in the stalled-slave watchdog.
module wb_bus_arbiter #(
    parameter int NUM_M          = 2,
    parameter int AW             = 32,
    parameter int DW             = 32,
    parameter int TIMEOUT_CYCLES = 256,
    localparam int SW            = DW / 8
) (
    input  logic                wb_clk,
    input  logic                wb_rst_n,
    input  logic [NUM_M-1:0]    m_cyc,
    input  logic [NUM_M-1:0]    m_stb,
    input  logic [NUM_M-1:0]    m_we,
    input  logic [NUM_M*AW-1:0] m_adr,
    input  logic [NUM_M*DW-1:0] m_dat_w,
    input  logic [NUM_M*SW-1:0] m_sel,
    output logic [DW-1:0]       m_dat_r,
    output logic [NUM_M-1:0]    m_ack,
    output logic [NUM_M-1:0]    m_err,
    output logic [NUM_M-1:0]    m_gnt,
    output logic                s_cyc,
    output logic                s_stb,
    output logic                s_we,
    output logic [AW-1:0]       s_adr,
    output logic [DW-1:0]       s_dat_w,
    output logic [SW-1:0]       s_sel,
    input  logic [DW-1:0]       s_dat_r,
    input  logic                s_ack
);

    localparam int LW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

    if (NUM_M < 2 || NUM_M > 4 || TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_param
        $error("wb_bus_arbiter: illegal parameter value");
    end

    typedef enum logic {IDLE, OWN} state_t;

    state_t           state_q, state_d;
    logic [NUM_M-1:0] gnt_q, gnt_d;
    logic [LW-1:0]    last_q, last_d;
    logic [LW:0]      pick;
    logic             cyc_raw, stb_raw;
    logic             abort;

    // Returns {found, index} of the first requester after 'last', wrapping around.
    function automatic logic [LW:0] rr_pick(input logic [NUM_M-1:0] req, input logic [LW-1:0] last);
        logic [LW:0] res;
        int          idx;
        res = '0;
        for (int k = NUM_M; k >= 1; k--) begin
            idx = (int'(last) + k) % NUM_M;
            if (req[idx]) res = {1'b1, LW'(idx)};
        end
        return res;
    endfunction

    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            last_q  <= LW'(NUM_M - 1);
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            last_q  <= last_d;
        end
    end

    // While granted, last_q is the owner; a dropped owner can never re-win in the same cycle.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        last_d  = last_q;
        pick    = rr_pick(m_cyc, last_q);
        case (state_q)
            IDLE: begin
                if (pick[LW]) begin
                    state_d = OWN;
                    gnt_d   = NUM_M'(1) << pick[LW-1:0];
                    last_d  = pick[LW-1:0];
                end
            end
            OWN: begin
                if (!m_cyc[last_q]) begin
                    if (pick[LW]) begin
                        gnt_d  = NUM_M'(1) << pick[LW-1:0];
                        last_d = pick[LW-1:0];
                    end else begin
                        state_d = IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        cyc_raw = 1'b0;
        stb_raw = 1'b0;
        s_we    = 1'b0;
        s_adr   = '0;
        s_dat_w = '0;
        s_sel   = '0;
        if (state_q == OWN) begin
            cyc_raw = m_cyc[last_q];
            stb_raw = m_stb[last_q];
            s_we    = m_we[last_q];
            s_adr   = m_adr[int'(last_q)*AW +: AW];
            s_dat_w = m_dat_w[int'(last_q)*DW +: DW];
            s_sel   = m_sel[int'(last_q)*SW +: SW];
        end
    end

`ifdef WB_BUS_ARBITER_TIMEOUT_EN
    logic [15:0] wd_cnt_q;
    logic        abort_q;
    logic        wd_run;
    logic        timeout;

    assign wd_run  = cyc_raw & stb_raw & ~s_ack & ~abort_q;
    assign timeout = wd_run && (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));

    // abort_q keeps the slave strobes low until the aborted owner releases cyc.
    always_ff @(posedge wb_clk or negedge wb_rst_n) begin
        if (!wb_rst_n) begin
            wd_cnt_q <= '0;
            abort_q  <= 1'b0;
        end else if (gnt_d != gnt_q) begin
            wd_cnt_q <= '0;
            abort_q  <= 1'b0;
        end else if (timeout) begin
            wd_cnt_q <= '0;
            abort_q  <= 1'b1;
        end else if (s_ack) begin
            wd_cnt_q <= '0;
        end else if (wd_run) begin
            wd_cnt_q <= wd_cnt_q + 16'd1;
        end
    end

    assign abort = abort_q | timeout;
    assign m_err = timeout ? gnt_q : '0;
`else
    assign abort = 1'b0;
    assign m_err = '0;
`endif

    assign s_cyc   = cyc_raw & ~abort;
    assign s_stb   = stb_raw & ~abort;
    assign m_ack   = {NUM_M{s_ack & ~abort}} & gnt_q;
    assign m_gnt   = gnt_q;
    assign m_dat_r = s_dat_r;

endmodule
